// File: rtl/accel_pkg.sv
// -----------------------------------------------------------------------------
// accel_pkg
// Shared definitions for the accelerator output paths.
//   - Default accumulator / buffer-address widths.
//   - Drain-side FSM state encoding (IDLE/STREAM/FLUSH/DONE).
//   - saturate(): clamps a wide signed value into a dw-bit signed range.
//     The result is returned at 64 bits; callers keep the low dw bits.
// -----------------------------------------------------------------------------
package accel_pkg;

   localparam int ACC_WIDTH_DEF  = 32;
   localparam int ADDR_WIDTH_DEF = 12;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_STREAM = 2'd1;
   localparam logic [1:0] ST_FLUSH  = 2'd2;
   localparam logic [1:0] ST_DONE   = 2'd3;

   function automatic logic signed [63:0] saturate(input logic signed [63:0] s,
                                                   input int unsigned        dw);
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      max_v = (64'sd1 <<< (dw - 1)) - 64'sd1;
      min_v = -(64'sd1 <<< (dw - 1));
      if (s > max_v)      return max_v;
      else if (s < min_v) return min_v;
      else                return s;
   endfunction

endpackage

// File: rtl/result_streamer_if.sv
// -----------------------------------------------------------------------------
// result_streamer_if
// Bundles the output-buffer read port and the transmit stream.
//   mem_rd_en / mem_rd_addr : read strobe and address (streamer -> buffer)
//   mem_rd_data             : signed word, valid the cycle after mem_rd_en
//   tx_valid / tx_data      : requantized sample stream (streamer -> sink)
//   tx_ready                : sink acceptance
// master = the streamer, slave = buffer + sink side.
// -----------------------------------------------------------------------------
interface result_streamer_if #(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = 32,
   parameter int ADDR_WIDTH = 12
) ();

   logic                         mem_rd_en;
   logic        [ADDR_WIDTH-1:0] mem_rd_addr;
   logic signed [ACC_WIDTH-1:0]  mem_rd_data;
   logic                         tx_valid;
   logic                         tx_ready;
   logic signed [DATA_WIDTH-1:0] tx_data;

   modport master (
      output mem_rd_en, mem_rd_addr, tx_valid, tx_data,
      input  mem_rd_data, tx_ready
   );

   modport slave (
      input  mem_rd_en, mem_rd_addr, tx_valid, tx_data,
      output mem_rd_data, tx_ready
   );

endinterface

// File: rtl/result_prefetch_fifo.sv
// -----------------------------------------------------------------------------
// result_prefetch_fifo
// Small synchronous FIFO with show-ahead head and occupancy count.
//   clk, rst_n : clock, async active-low reset (pointers/count only)
//   push, push_data : write one entry (caller guarantees not full)
//   pop             : drop the head entry (caller guarantees not empty)
//   head, empty     : current head entry and empty flag
//   occupancy       : number of stored entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module result_prefetch_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int OCC_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic             empty,
   output logic [OCC_W-1:0] occupancy
);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [OCC_W-1:0] occ_q;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge values of the others, independent of block evaluation order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ_q  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   occ_q <= occ_q + OCC_W'(1);
            2'b01:   occ_q <= occ_q - OCC_W'(1);
            default: occ_q <= occ_q;
         endcase
      end
   end

   // NOTE: the data array has no reset; emptiness is tracked by the pointers,
   // so resetting storage would only cost flops and a reset fan-out.
   always_ff @(posedge clk) begin
      if (push) storage[wr_ptr] <= push_data;
   end

   assign head      = storage[rd_ptr];
   assign empty     = (occ_q == '0);
   assign occupancy = occ_q;

endmodule

// File: rtl/result_streamer.sv
// -----------------------------------------------------------------------------
// result_streamer
// Drains out_count accumulator words from the output buffer in address order,
// requantizes each (arithmetic right shift by cfg_shift, then signed
// saturation to DATA_WIDTH) and sends them on a valid/ready stream.
//   clk, rst_n          : clock, async active-low reset
//   start               : one-cycle request, only honoured in IDLE
//   out_count, cfg_shift: job length and shift, latched on start
//   busy                : high whenever not IDLE
//   done                : one-cycle pulse after the last beat is accepted
//   bus (master)        : buffer read port + transmit stream
// Reads are credited against a FIFO_DEPTH prefetch FIFO: a read issues only
// when stored entries plus the one-cycle in-flight read leave a free slot,
// so a returning word always finds room.
// -----------------------------------------------------------------------------
module result_streamer
   import accel_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
   parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] out_count,
   input  logic [4:0]            cfg_shift,
   output logic                  busy,
   output logic                  done,
   result_streamer_if.master     bus
);

   localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;

   logic [1:0]            state_q;
   logic [ADDR_WIDTH-1:0] count_q;
   logic [ADDR_WIDTH-1:0] rd_ptr_q;
   logic [ADDR_WIDTH-1:0] sent_q;
   logic [4:0]            shift_q;
   logic                  inflight_q;

   logic [OCC_W-1:0]      occ;
   logic [OCC_W:0]        credit_used;
   logic                  fifo_empty;
   logic [DATA_WIDTH-1:0] fifo_head;
   logic                  tx_valid_int;
   logic                  rd_en;
   logic                  last_issue;
   logic                  beat;
   logic                  last_beat;

   logic signed [63:0]    acc_ext;
   logic signed [63:0]    shifted;
   logic signed [63:0]    sat_val;
   logic [DATA_WIDTH-1:0] push_data;
   logic                  unused_sat_hi;

   // A pop in the same cycle is deliberately not credited back.
   assign credit_used  = {1'b0, occ} + (OCC_W + 1)'(inflight_q);
   assign rd_en        = (state_q == ST_STREAM) && (credit_used < (OCC_W + 1)'(FIFO_DEPTH));
   assign last_issue   = rd_en && (rd_ptr_q == count_q - ADDR_WIDTH'(1));
   assign tx_valid_int = !fifo_empty;
   assign beat         = tx_valid_int && bus.tx_ready;
   assign last_beat    = beat && (sent_q == count_q - ADDR_WIDTH'(1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         shift_q    <= '0;
         rd_ptr_q   <= '0;
         sent_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         inflight_q <= rd_en;
         if (beat) sent_q <= sent_q + ADDR_WIDTH'(1);
         case (state_q)
            ST_IDLE: begin
               if (start) begin
                  count_q  <= out_count;
                  shift_q  <= cfg_shift;
                  rd_ptr_q <= '0;
                  sent_q   <= '0;
                  state_q  <= (out_count != '0) ? ST_STREAM : ST_DONE;
               end
            end
            ST_STREAM: begin
               // The pointer parks at 0 after the final read so it never
               // reaches the latched count.
               if (last_issue) begin
                  rd_ptr_q <= '0;
                  state_q  <= ST_FLUSH;
               end else if (rd_en) begin
                  rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
               end
            end
            ST_FLUSH: begin
               if (last_beat) state_q <= ST_DONE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Requantize the returning word before it enters the FIFO.
   assign acc_ext       = {{(64 - ACC_WIDTH){bus.mem_rd_data[ACC_WIDTH-1]}}, bus.mem_rd_data};
   assign shifted       = acc_ext >>> shift_q;
   assign sat_val       = saturate(shifted, DATA_WIDTH);
   assign push_data     = sat_val[DATA_WIDTH-1:0];
   assign unused_sat_hi = ^sat_val[63:DATA_WIDTH];

   result_prefetch_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (inflight_q),
      .push_data (push_data),
      .pop       (beat),
      .head      (fifo_head),
      .empty     (fifo_empty),
      .occupancy (occ)
   );

   assign busy            = (state_q != ST_IDLE);
   assign done            = (state_q == ST_DONE);
   assign bus.mem_rd_en   = rd_en;
   assign bus.mem_rd_addr = rd_ptr_q;
   assign bus.tx_valid    = tx_valid_int;
   // Gate the head so idle/reset output is 0 rather than stale storage.
   assign bus.tx_data     = tx_valid_int ? fifo_head : '0;

endmodule

// File: tb/tb_result_streamer.sv
// -----------------------------------------------------------------------------
// tb_result_streamer
// Self-checking bench: a buffer model answering reads one cycle later, a
// per-job monitor sampling on the falling edge, table-driven saturation
// vectors, directed corner sequences and randomized jobs checked against an
// arithmetic requantization model.
// -----------------------------------------------------------------------------
module tb_result_streamer;

   localparam int DW    = 8;
   localparam int AW    = 32;
   localparam int ADW   = 12;
   localparam int LIMIT = 3000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [ADW-1:0] out_count;
   logic [4:0]    cfg_shift;
   logic          busy;
   logic          done;

   result_streamer_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ADDR_WIDTH(ADW)) bus ();

   result_streamer #(
      .DATA_WIDTH (DW),
      .ACC_WIDTH  (AW),
      .ADDR_WIDTH (ADW),
      .FIFO_DEPTH (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .out_count (out_count),
      .cfg_shift (cfg_shift),
      .busy      (busy),
      .done      (done),
      .bus       (bus)
   );

   always #5 clk = ~clk;

   logic signed [AW-1:0] mem [4096];

   always @(posedge clk) begin
      if (bus.mem_rd_en) bus.mem_rd_data <= mem[bus.mem_rd_addr];
   end

   int vectors    = 0;
   int miscompares = 0;

   task automatic check(input string name, input longint act, input longint exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Requantization from first principles: floor division by 2^sh, then clamp.
   function automatic int ref_q(input int acc, input int sh);
      longint a;
      longint d;
      longint s;
      a = acc;
      d = longint'(1) << sh;
      if (a >= 0) s = a / d;
      else        s = -((-a + d - 1) / d);
      if (s > 127)  return 127;
      if (s < -128) return -128;
      return int'(s);
   endfunction

   // Per-job observations.
   int got[$];
   int done_cyc, first_v, last_v, valid_cycles, rd_cycles, bad_addr;
   int stall_err, max_out, busy_after;
   int rd_cnt [4096];

   function automatic int got_at(input int i);
      if (i < got.size()) return got[i];
      return 9999;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_busy"},  busy, 0);
      check({tag, "_done"},  done, 0);
      check({tag, "_rd_en"}, bus.mem_rd_en, 0);
      check({tag, "_addr"},  bus.mem_rd_addr, 0);
      check({tag, "_valid"}, bus.tx_valid, 0);
      check({tag, "_data"},  bus.tx_data, 0);
   endtask

   // mode: 0 ready high, 1 alternating, 2 random.
   task automatic run_job(input int n, input int sh, input int mode,
                          input int inject_at, input int abort_beats);
      int  issued, accepted;
      bit  pv, pr, seen_done, finished;
      logic signed [DW-1:0] pd;
      got.delete();
      done_cyc = -1; first_v = -1; last_v = -1; valid_cycles = 0; rd_cycles = 0;
      bad_addr = 0; stall_err = 0; max_out = 0; busy_after = -1;
      foreach (rd_cnt[i]) rd_cnt[i] = 0;
      issued = 0; accepted = 0; pv = 0; pr = 0; pd = '0; seen_done = 0; finished = 0;

      @(negedge clk);
      start = 1'b1; out_count = ADW'(n); cfg_shift = 5'(sh);
      @(posedge clk);          // edge 0
      #1 start = 1'b0;
      for (int k = 1; k <= LIMIT && !finished; k++) begin
         if (k == inject_at) begin
            start = 1'b1; out_count = ADW'(7); cfg_shift = 5'd0;
         end else begin
            start = 1'b0;
         end
         case (mode)
            0:       bus.tx_ready = 1'b1;
            1:       bus.tx_ready = k[0];
            default: bus.tx_ready = 1'($urandom_range(0, 1));
         endcase
         @(negedge clk);
         if (seen_done) begin
            busy_after = busy;
            finished = 1;
         end else begin
            if (pv && !pr && (!bus.tx_valid || bus.tx_data !== pd)) stall_err++;
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (bus.mem_rd_en) begin
               rd_cycles++; issued++;
               if (int'(bus.mem_rd_addr) < n) rd_cnt[bus.mem_rd_addr]++;
               else bad_addr++;
            end
            if (bus.tx_valid) begin
               valid_cycles++;
               if (first_v < 0) first_v = k;
               last_v = k;
            end
            if (bus.tx_valid && bus.tx_ready) begin
               got.push_back(int'(bus.tx_data));
               accepted++;
            end
            pv = bus.tx_valid; pr = bus.tx_ready; pd = bus.tx_data;
            if (done) begin
               done_cyc = k;
               seen_done = 1;
            end
            if (abort_beats > 0 && got.size() == abort_beats) begin
               rst_n = 1'b0;
               #1 check_idle("mid_reset");
               @(posedge clk);
               #1 rst_n = 1'b1;
               start = 1'b0;
               return;
            end
            @(posedge clk);
            #1;
         end
      end
      start = 1'b0;
      check("done_seen", (done_cyc > 0) ? 1 : 0, 1);
   endtask

   task automatic check_stream(input string tag, input int n, input int sh);
      int errs, reads_bad;
      errs = 0; reads_bad = 0;
      check({tag, "_beats"}, got.size(), n);
      for (int i = 0; i < n; i++) begin
         if (got_at(i) != ref_q(mem[i], sh)) begin
            errs++;
            if (errs <= 4)
               $display("FAIL %s_beat%0d: got %0d expected %0d", tag, i, got_at(i), ref_q(mem[i], sh));
         end
         if (rd_cnt[i] != 1) reads_bad++;
      end
      check({tag, "_data_errs"}, errs, 0);
      check({tag, "_reads_once"}, reads_bad, 0);
      check({tag, "_bad_addr"}, bad_addr, 0);
      check({tag, "_read_total"}, rd_cycles, n);
      check({tag, "_stall_stable"}, stall_err, 0);
      check({tag, "_credit_le4"}, (max_out <= 4) ? 1 : 0, 1);
   endtask

   typedef struct {
      int acc;
      int sh;
      int expv;
   } sat_vec_t;

   sat_vec_t vecs [10];

   task automatic fill_random(input int n);
      for (int i = 0; i < n; i++) begin
         int v;
         v = int'($urandom);
         v = v >>> $urandom_range(0, 24);
         mem[i] = v;
      end
   endtask

   initial begin
      vecs[0] = '{1000, 0, 127};   vecs[1] = '{-1000, 0, -128};
      vecs[2] = '{127, 0, 127};    vecs[3] = '{-128, 0, -128};
      vecs[4] = '{5, 0, 5};
      vecs[5] = '{1000, 3, 125};   vecs[6] = '{-1000, 3, -125};
      vecs[7] = '{127, 3, 15};     vecs[8] = '{-128, 3, -16};
      vecs[9] = '{5, 3, 0};

      rst_n = 1'b0; start = 1'b0; out_count = '0; cfg_shift = '0; bus.tx_ready = 1'b0;
      foreach (mem[i]) mem[i] = '0;
      #1 check_idle("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Basic stream with exact latency.
      mem[0] = 0; mem[1] = 16; mem[2] = 32; mem[3] = 48;
      run_job(4, 2, 0, 0, 0);
      for (int i = 0; i < 4; i++) check($sformatf("basic_beat%0d", i), got_at(i), 4 * i);
      check("basic_first_valid", first_v, 3);
      check("basic_last_valid", last_v, 6);
      check("basic_done_cycle", done_cyc, 7);
      check("basic_busy_after", busy_after, 0);

      // Saturation vectors from the table.
      for (int g = 0; g < 2; g++) begin
         for (int j = 0; j < 5; j++) mem[j] = vecs[g * 5 + j].acc;
         run_job(5, vecs[g * 5].sh, 0, 0, 0);
         for (int j = 0; j < 5; j++)
            check($sformatf("sat_sh%0d_%0d", vecs[g * 5].sh, j), got_at(j), vecs[g * 5 + j].expv);
         check("sat_done_cycle", done_cyc, 8);
      end

      // Backpressure: alternating, then random ready.
      for (int i = 0; i < 16; i++) mem[i] = i;
      run_job(16, 0, 1, 0, 0);
      check_stream("bp_alt", 16, 0);
      run_job(16, 0, 2, 0, 0);
      check_stream("bp_rand", 16, 0);

      // Zero count.
      run_job(0, 0, 0, 0, 0);
      check("zero_rd_cycles", rd_cycles, 0);
      check("zero_valid_cycles", valid_cycles, 0);
      check("zero_done_cycle", done_cyc, 1);

      // Reset mid-stream, then a fresh short job.
      fill_random(16);
      run_job(16, 4, 0, 0, 5);
      run_job(3, 4, 0, 0, 0);
      check_stream("after_reset", 3, 4);
      check("after_reset_done_cycle", done_cyc, 6);

      // Full frame with a start pulse while busy.
      fill_random(196);
      run_job(196, 7, 0, 50, 0);
      check_stream("frame", 196, 7);
      check("frame_done_cycle", done_cyc, 199);
      check("frame_first_valid", first_v, 3);

      // Randomized jobs against the reference model.
      for (int r = 0; r < 10; r++) begin
         int n, sh, mode;
         n    = $urandom_range(1, 40);
         sh   = $urandom_range(0, 31);
         mode = $urandom_range(0, 2);
         fill_random(n);
         run_job(n, sh, mode, 0, 0);
         check_stream($sformatf("rand%0d", r), n, sh);
         if (mode == 0) check($sformatf("rand%0d_done_cycle", r), done_cyc, n + 3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
